// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
//   REG_AW / XLEN : register index and data widths
//   wb_req_t      : pipeline writeback request {we, rd, data}
//   md_entry_t    : buffered MDU result {rd, data}
package rf_wb_arbiter_pkg;
  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } md_entry_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO, DEPTH entries (power of 2) of WIDTH bits.
//   push/wdata : enqueue; push and pop may coincide, including at full
//   pop        : dequeue head (caller guarantees !empty)
//   rdata      : current head, valid while !empty
//   full/empty : occupancy flags
module rf_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q[AW-1:0]] = wdata;
      wr_d = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
  end

  assign rdata = mem_q[rd_q[AW-1:0]];
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
    mem_q <= mem_d;
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between pipeline writeback and MDU results.
//   wb_*      : pipeline writeback request; wb_stall holds the WB stage
//   md_issue* : MDU issue, marks destination busy in the scoreboard
//   md_*      : MDU result handshake (md_valid/md_ready) into the result FIFO
//   id_*      : decode-stage operands; hazard_stall on busy registers
//   busy_vec  : scoreboard (debug)
//   rf_*      : register-file write port
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              wb_stall,
  input  logic              md_issue,
  input  logic [REG_AW-1:0] md_issue_rd,
  input  logic              md_valid,
  input  logic [REG_AW-1:0] md_rd,
  input  logic [XLEN-1:0]   md_data,
  output logic              md_ready,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_rd_we,
  output logic              hazard_stall,
  output logic [31:0]       busy_vec,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [XLEN-1:0]   rf_wd
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  wb_req_t        wb_req;
  md_entry_t      push_entry, head;
  logic           full, empty, push, pop, force_drain, wb_active;
  logic [SW-1:0]  starve_q, starve_d;
  logic [31:0]    busy_q, busy_d;

  assign wb_req     = '{we: wb_we, rd: wb_rd, data: wb_data};
  assign push_entry = '{rd: md_rd, data: md_data};

  rf_wb_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH ($bits(md_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    // A writeback to x0 is architecturally a no-op and never takes the port.
    wb_active   = wb_req.we && (wb_req.rd != '0);
    force_drain = (starve_q == STARVE_LIM) && !empty;
    md_ready    = !rst && !full;
    push        = md_valid && md_ready;
    pop         = !rst && !empty && (force_drain || !wb_active);
    wb_stall    = !rst && force_drain && wb_active;

    rf_we = 1'b0;
    rf_wa = '0;
    rf_wd = '0;
    if (pop) begin
      rf_we = 1'b1;
      rf_wa = head.rd;
      rf_wd = head.data;
    end else if (!rst && wb_active) begin
      rf_we = 1'b1;
      rf_wa = wb_req.rd;
      rf_wd = wb_req.data;
    end

    starve_d = starve_q;
    if (empty || pop)             starve_d = '0;
    else if (starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;

    // Set is applied after clear so a re-issue to the popping register wins.
    busy_d = busy_q;
    if (pop) busy_d[head.rd] = 1'b0;
    if (md_issue && (md_issue_rd != '0)) busy_d[md_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;

    // busy_q still reflects a register popping this cycle: the RF commits it late.
    hazard_stall = !rst &&
      ((id_use_rs1 && (id_rs1 != '0) && busy_q[id_rs1]) ||
       (id_use_rs2 && (id_rs2 != '0) && busy_q[id_rs2]) ||
       (id_rd_we   && (id_rd  != '0) && busy_q[id_rd]));
  end

  assign busy_vec = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      busy_q   <= '0;
    end else begin
      starve_q <= starve_d;
      busy_q   <= busy_d;
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  logic        clk, rst;
  logic        wb_we, wb_stall, md_issue, md_valid, md_ready;
  logic [4:0]  wb_rd, md_issue_rd, md_rd, id_rs1, id_rs2, id_rd, rf_wa;
  logic [31:0] wb_data, md_data, busy_vec, rf_wd;
  logic        id_use_rs1, id_use_rs2, id_rd_we, hazard_stall, rf_we;

  int checks = 0;
  int errors = 0;

  rf_wb_arbiter #(.QDEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd_we(id_rd_we),
    .hazard_stall(hazard_stall), .busy_vec(busy_vec),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exp_we;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_rd = 0; wb_data = 0;
    md_issue = 0; md_issue_rd = 0; md_valid = 0; md_rd = 0; md_data = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_rd_we = 0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hA5A5_A5A5, 1'b1, 5'd5,  32'hA5A5_A5A5};
    vecs[1] = '{1'b1, 5'd0,  32'hDEAD_BEEF, 1'b0, 5'd0,  32'h0};
    vecs[2] = '{1'b0, 5'd9,  32'h1234_5678, 1'b0, 5'd0,  32'h0};
    vecs[3] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'hFFFF_FFFF};
    vecs[4] = '{1'b1, 5'd1,  32'h0000_0001, 1'b1, 5'd1,  32'h0000_0001};

    // Reset with activity on every input: all outputs must be quiet.
    idle_inputs();
    rst = 1;
    wb_we = 1; wb_rd = 5; md_valid = 1; md_rd = 6; md_issue = 1; md_issue_rd = 8;
    id_use_rs1 = 1; id_rs1 = 8;
    step();
    @(negedge clk);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_md_ready", md_ready, 0);
    chk("rst_wb_stall", wb_stall, 0);
    chk("rst_hazard", hazard_stall, 0);
    step();
    idle_inputs();
    rst = 0;
    @(negedge clk);
    chk("post_rst_busy", busy_vec, 0);
    chk("post_rst_md_ready", md_ready, 1);
    chk("post_rst_rf_we", rf_we, 0);
    step();

    // Pipeline-only writes with an empty FIFO.
    for (int i = 0; i < 5; i++) begin
      wb_we = vecs[i].wb_we; wb_rd = vecs[i].wb_rd; wb_data = vecs[i].wb_data;
      @(negedge clk);
      chk($sformatf("vec%0d_rf_we", i), rf_we, vecs[i].exp_we);
      chk($sformatf("vec%0d_rf_wa", i), rf_wa, vecs[i].exp_wa);
      chk($sformatf("vec%0d_rf_wd", i), rf_wd, vecs[i].exp_wd);
      chk($sformatf("vec%0d_wb_stall", i), wb_stall, 0);
      step();
    end
    idle_inputs();

    // Issue to x0 never marks busy.
    md_issue = 1; md_issue_rd = 0;
    step();
    md_issue = 0;
    @(negedge clk);
    chk("issue_x0_busy", busy_vec, 0);
    step();

    // RAW hazard on rd=7, then MDU result retires it.
    md_issue = 1; md_issue_rd = 7;
    step();
    md_issue = 0;
    id_use_rs1 = 1; id_rs1 = 7;
    @(negedge clk);
    chk("h7_busy", busy_vec, 32'h80);
    chk("h7_rs1", hazard_stall, 1);
    id_use_rs1 = 0; id_use_rs2 = 1; id_rs2 = 7;
    #1 chk("h7_rs2", hazard_stall, 1);
    id_use_rs2 = 0; id_rd_we = 1; id_rd = 7;
    #1 chk("h7_rd", hazard_stall, 1);
    id_rd = 6;
    #1 chk("h7_other_rd", hazard_stall, 0);
    id_rd_we = 0; id_use_rs1 = 1; id_rs1 = 7;
    step();
    md_valid = 1; md_rd = 7; md_data = 32'h12;
    @(negedge clk);
    chk("h7_accept_ready", md_ready, 1);
    chk("h7_no_bypass", rf_we, 0);
    step();
    md_valid = 0;
    @(negedge clk);
    chk("h7_pop_we", rf_we, 1);
    chk("h7_pop_wa", rf_wa, 7);
    chk("h7_pop_wd", rf_wd, 32'h12);
    chk("h7_hazard_during_pop", hazard_stall, 1);
    step();
    @(negedge clk);
    chk("h7_busy_cleared", busy_vec, 0);
    chk("h7_hazard_dropped", hazard_stall, 0);
    chk("h7_idle", rf_we, 0);
    step();
    idle_inputs();

    // Starvation: pipeline writes every cycle while two results wait.
    wb_we = 1; wb_rd = 10; wb_data = 32'hD0D0_0000;
    md_valid = 1; md_rd = 11; md_data = 32'h111;
    @(negedge clk);
    chk("sv_a_wa", rf_wa, 10);
    step();
    md_rd = 12; md_data = 32'h222;
    @(negedge clk);
    chk("sv_b_ready", md_ready, 1);
    step();
    md_valid = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("sv_wait%0d_ready", c), md_ready, 0);
      chk($sformatf("sv_wait%0d_wa", c), rf_wa, 10);
      chk($sformatf("sv_wait%0d_stall", c), wb_stall, 0);
      step();
    end
    @(negedge clk);
    chk("sv_force_we", rf_we, 1);
    chk("sv_force_wa", rf_wa, 11);
    chk("sv_force_wd", rf_wd, 32'h111);
    chk("sv_force_stall", wb_stall, 1);
    step();
    @(negedge clk);
    chk("sv_held_wa", rf_wa, 10);
    chk("sv_held_wd", rf_wd, 32'hD0D0_0000);
    chk("sv_held_stall", wb_stall, 0);
    chk("sv_held_ready", md_ready, 1);
    step();
    wb_we = 0;
    @(negedge clk);
    chk("sv_drain_wa", rf_wa, 12);
    chk("sv_drain_wd", rf_wd, 32'h222);
    step();
    idle_inputs();

    // x0 writeback does not block the FIFO head.
    md_valid = 1; md_rd = 3; md_data = 32'h33;
    step();
    md_valid = 0;
    wb_we = 1; wb_rd = 0; wb_data = 32'hBAD0_0BAD;
    @(negedge clk);
    chk("x0_we", rf_we, 1);
    chk("x0_wa", rf_wa, 3);
    chk("x0_wd", rf_wd, 32'h33);
    chk("x0_stall", wb_stall, 0);
    step();
    idle_inputs();

    // Same-cycle pop of rd=9 and re-issue to rd=9: set wins.
    md_issue = 1; md_issue_rd = 9;
    step();
    md_issue = 0;
    md_valid = 1; md_rd = 9; md_data = 32'h99;
    step();
    md_valid = 0;
    md_issue = 1; md_issue_rd = 9;
    @(negedge clk);
    chk("sc_pop_wa", rf_wa, 9);
    step();
    md_issue = 0;
    @(negedge clk);
    chk("sc_busy9", busy_vec, 32'h200);
    step();
    md_valid = 1; md_rd = 9; md_data = 32'h9A;
    step();
    md_valid = 0;
    step();
    @(negedge clk);
    chk("sc_busy_clear", busy_vec, 0);
    step();

    // Full FIFO, then reset mid-operation.
    wb_we = 1; wb_rd = 4; wb_data = 32'h4444;
    md_issue = 1; md_issue_rd = 20;
    md_valid = 1; md_rd = 21; md_data = 32'h21;
    step();
    md_issue = 0;
    md_rd = 22; md_data = 32'h22;
    step();
    md_valid = 0;
    id_use_rs1 = 1; id_rs1 = 20;
    @(negedge clk);
    chk("fr_full_ready", md_ready, 0);
    chk("fr_busy20", busy_vec, 32'h0010_0000);
    rst = 1;
    #1;
    chk("fr_rst_we", rf_we, 0);
    chk("fr_rst_ready", md_ready, 0);
    chk("fr_rst_stall", wb_stall, 0);
    chk("fr_rst_hazard", hazard_stall, 0);
    step();
    rst = 0;
    wb_we = 0;
    @(negedge clk);
    chk("fr_post_busy", busy_vec, 0);
    chk("fr_post_ready", md_ready, 1);
    chk("fr_post_we0", rf_we, 0);
    chk("fr_post_hazard", hazard_stall, 0);
    step();
    @(negedge clk);
    chk("fr_post_we1", rf_we, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
